// File: rtl/fp_divsqrt_seq_if.sv
// Handshake bundle between issue/writeback logic and the div/sqrt sequencer.
// The slave side belongs to the sequencer and the master side to the pipeline.
interface fp_divsqrt_seq_if;
    logic        issue;
    logic        issue_sqrt;
    logic [4:0]  issue_rd;
    logic        e3w;
    logic        stall_div_sqrt;
    logic        busy;
    logic        ds_start;
    logic        ds_op;
    logic        ds_iter_en;
    logic [2:0]  ds_iter_idx;
    logic        ds_round;
    logic        ds_wf;
    logic [4:0]  ds_wn;
    logic        err;
    logic [15:0] perf_ops;
    logic [31:0] perf_stall;

    modport master (
        output issue, issue_sqrt, issue_rd, e3w,
        input  stall_div_sqrt, busy, ds_start, ds_op, ds_iter_en,
        input  ds_iter_idx, ds_round, ds_wf, ds_wn, err,
        input  perf_ops, perf_stall
    );

    modport slave (
        input  issue, issue_sqrt, issue_rd, e3w,
        output stall_div_sqrt, busy, ds_start, ds_op, ds_iter_en,
        output ds_iter_idx, ds_round, ds_wf, ds_wn, err,
        output perf_ops, perf_stall
    );
endinterface

// File: rtl/fp_divsqrt_seq.sv
// Sequencer for the shared multi-cycle FP divide/sqrt datapath.
// Optional performance counters are built when FP_DIVSQRT_PERF_EN is defined.
module fp_divsqrt_seq #(
    parameter int DIV_ITER     = 3,
    parameter int SQRT_ITER    = 5,
    parameter int CYC_PER_ITER = 2
) (
    input  logic clk,
    input  logic rst,
    fp_divsqrt_seq_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ITER  = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;

    localparam logic [2:0] DIV_N    = 3'(DIV_ITER);
    localparam logic [2:0] SQRT_N   = 3'(SQRT_ITER);
    localparam logic [2:0] LAST_CYC = 3'(CYC_PER_ITER - 1);

    logic [2:0] state;
    logic [2:0] n_iter;
    logic [2:0] cyc;
    logic [2:0] idx;
    logic       op;
    logic [4:0] rd;
    logic       err_q;
    logic       iter_fire;
    logic       last_iter;
    logic       idle;

    assign idle      = (state == S_IDLE);
    assign iter_fire = (state == S_ITER) && (cyc == LAST_CYC);
    assign last_iter = (idx == n_iter - 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            n_iter <= 3'd0;
            cyc    <= 3'd0;
            idx    <= 3'd0;
            op     <= 1'b0;
            rd     <= 5'd0;
            err_q  <= 1'b0;
        end else begin
            if (bus.issue && !idle)
                err_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (bus.issue) begin
                        state  <= S_LOAD;
                        op     <= bus.issue_sqrt;
                        rd     <= bus.issue_rd;
                        n_iter <= bus.issue_sqrt ? SQRT_N : DIV_N;
                    end
                end
                S_LOAD: begin
                    state <= S_ITER;
                    cyc   <= 3'd0;
                    idx   <= 3'd0;
                end
                S_ITER: begin
                    if (iter_fire) begin
                        cyc <= 3'd0;
                        if (last_iter) begin
                            // index parks at 0 once iterating is over
                            idx   <= 3'd0;
                            state <= S_ROUND;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cyc <= cyc + 3'd1;
                    end
                end
                S_ROUND: state <= S_WB;
                S_WB: begin
                    // the pipeline E3 write owns the port while e3w is high
                    if (!bus.e3w) begin
                        state  <= S_IDLE;
                        op     <= 1'b0;
                        rd     <= 5'd0;
                        n_iter <= 3'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy           = !idle;
    assign bus.stall_div_sqrt = !idle;
    assign bus.ds_start       = (state == S_LOAD);
    assign bus.ds_op          = op;
    assign bus.ds_iter_en     = iter_fire;
    assign bus.ds_iter_idx    = idx;
    assign bus.ds_round       = (state == S_ROUND);
    assign bus.ds_wf          = (state == S_WB) && !bus.e3w;
    assign bus.ds_wn          = rd;
    assign bus.err            = err_q;

`ifdef FP_DIVSQRT_PERF_EN
    logic [15:0] ops_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ops_q   <= 16'd0;
            stall_q <= 32'd0;
        end else begin
            if (bus.ds_wf)
                ops_q <= ops_q + 16'd1;
            // stall cycles saturate rather than wrap
            if (!idle && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.perf_ops   = ops_q;
    assign bus.perf_stall = stall_q;
`else
    assign bus.perf_ops   = 16'd0;
    assign bus.perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_fp_divsqrt_seq.sv
// Self-checking bench for fp_divsqrt_seq against a cycle-timeline model
// derived from the operation latency rules.
module tb_fp_divsqrt_seq;

    localparam int DIV_N  = 3;
    localparam int SQRT_N = 5;
    localparam int CPI    = 2;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    fp_divsqrt_seq_if bus();

    fp_divsqrt_seq #(
        .DIV_ITER    (DIV_N),
        .SQRT_ITER   (SQRT_N),
        .CYC_PER_ITER(CPI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {busy,stall,start,op,iter_en,idx,round,wf,wn} at cycle t
    // after an issue at t=0, with 'stalls' e3w cycles at WB entry.
    function automatic logic [14:0] model(int t, bit sq, logic [4:0] rd,
                                          int stalls);
        int n, ie, rc, wb0, wbe;
        logic busy, start, op, en, rnd, wf, in_iter;
        logic [2:0] idx;
        logic [4:0] wn;
        n   = sq ? SQRT_N : DIV_N;
        ie  = 1 + n * CPI;
        rc  = ie + 1;
        wb0 = rc + 1;
        wbe = wb0 + stalls;
        busy    = (t >= 1) && (t <= wbe);
        start   = (t == 1);
        op      = busy ? sq : 1'b0;
        in_iter = (t >= 2) && (t <= ie);
        en      = in_iter && (((t - 1) % CPI) == 0);
        idx     = in_iter ? 3'((t - 2) / CPI) : 3'd0;
        rnd     = (t == rc);
        wf      = (t == wbe);
        wn      = busy ? rd : 5'd0;
        return {busy, busy, start, op, en, idx, rnd, wf, wn};
    endfunction

    function automatic int wb_end(bit sq, int stalls);
        return 3 + (sq ? SQRT_N : DIV_N) * CPI + stalls;
    endfunction

    function automatic logic [14:0] obs();
        return {bus.busy, bus.stall_div_sqrt, bus.ds_start, bus.ds_op,
                bus.ds_iter_en, bus.ds_iter_idx, bus.ds_round, bus.ds_wf,
                bus.ds_wn};
    endfunction

    task automatic step(input logic i, input logic s, input logic [4:0] r,
                        input logic e, input logic rs);
        @(posedge clk);
        #1;
        bus.issue      = i;
        bus.issue_sqrt = s;
        bus.issue_rd   = r;
        bus.e3w        = e;
        rst            = rs;
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (obs() !== 15'd0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset outs got=%h err=%b exp=0", obs(), bus.err);
        end
        checks++;
        if (bus.perf_ops !== 16'd0 || bus.perf_stall !== 32'd0) begin
            errors++;
            $display("FAIL reset perf got=%0d/%0d exp=0/0",
                     bus.perf_ops, bus.perf_stall);
        end
    endtask

    task automatic test_fdiv();
        logic [14:0] e;
        for (int t = 0; t <= 11; t++) begin
            step(t == 0, 1'b0, 5'd7, 1'b0, 1'b0);
            e = model(t, 1'b0, 5'd7, 0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL fdiv t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
    endtask

    task automatic test_fsqrt();
        logic [14:0] e;
        int pulses;
        pulses = 0;
        for (int t = 0; t <= 15; t++) begin
            step(t == 0, 1'b1, 5'd31, 1'b0, 1'b0);
            e = model(t, 1'b1, 5'd31, 0);
            if (bus.ds_iter_en === 1'b1) pulses++;
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL fsqrt t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
        checks++;
        if (pulses != SQRT_N) begin
            errors++;
            $display("FAIL fsqrt_pulses got=%0d exp=%0d", pulses, SQRT_N);
        end
    endtask

    task automatic test_e3w_stall();
        logic [14:0] e;
        int wb0;
        wb0 = wb_end(1'b0, 0);
        for (int t = 0; t <= 14; t++) begin
            step(t == 0, 1'b0, 5'd19,
                 (t >= wb0) && (t < wb0 + 3), 1'b0);
            e = model(t, 1'b0, 5'd19, 3);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL e3w_stall t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
    endtask

    task automatic test_issue_busy();
        logic [14:0] e;
        for (int t = 0; t <= 12; t++) begin
            if (t == 4) step(1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
            else        step(t == 0, 1'b0, 5'd9, 1'b0, 1'b0);
            e = model(t, 1'b0, 5'd9, 0);
            checks++;
            if (obs() !== e || bus.err !== (t >= 5)) begin
                errors++;
                $display("FAIL issue_busy t=%0d got=%h err=%b exp=%h err=%b",
                         t, obs(), bus.err, e, t >= 5);
            end
        end
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got=%b exp=0", bus.err);
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] e;
        int wf_seen;
        wf_seen = 0;
        for (int t = 0; t <= 5; t++) begin
            step(t == 0, 1'b1, 5'd12, 1'b0, t == 5);
            e = model(t, 1'b1, 5'd12, 0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL rst_mid t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
        for (int t = 6; t <= 16; t++) begin
            step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            if (bus.ds_wf !== 1'b0 || bus.busy !== 1'b0) wf_seen++;
        end
        checks++;
        if (wf_seen != 0) begin
            errors++;
            $display("FAIL rst_mid_idle got=%0d active cycles exp=0", wf_seen);
        end
        step(1'b1, 1'b1, 5'd21, 1'b0, 1'b1);
        for (int t = 0; t < 3; t++) begin
            step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            checks++;
            if (obs() !== 15'd0) begin
                errors++;
                $display("FAIL rst_issue t=%0d got=%h exp=0", t, obs());
            end
        end
        for (int t = 0; t <= 10; t++) begin
            step(t == 0, 1'b0, 5'd2, 1'b0, 1'b0);
            e = model(t, 1'b0, 5'd2, 0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL post_rst t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] e;
        int ops_exp, stall_exp, end0, end1;
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        end0 = wb_end(1'b0, 0);
        end1 = wb_end(1'b1, 0);
        for (int t = 0; t <= end0 + end1 + 2; t++) begin
            if (t <= end0) begin
                step(t == 0, 1'b0, 5'd4, 1'b0, 1'b0);
                e = model(t, 1'b0, 5'd4, 0);
            end else begin
                step(t == end0 + 1, 1'b1, 5'd5, 1'b0, 1'b0);
                e = model(t - end0 - 1, 1'b1, 5'd5, 0);
            end
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL b2b t=%0d got=%h exp=%h", t, obs(), e);
            end
        end
`ifdef FP_DIVSQRT_PERF_EN
        ops_exp = 2;
        stall_exp = end0 + end1;
`else
        ops_exp = 0;
        stall_exp = 0;
`endif
        checks++;
        if (bus.perf_ops !== 16'(ops_exp) || bus.perf_stall !== 32'(stall_exp)) begin
            errors++;
            $display("FAIL b2b_perf got=%0d/%0d exp=%0d/%0d",
                     bus.perf_ops, bus.perf_stall, ops_exp, stall_exp);
        end
    endtask

    task automatic test_random();
        logic [14:0] e;
        bit sq;
        logic [4:0] rd;
        int stalls, gap, wb0, wbe, n_ops, n_stall;
        logic e3;
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        n_ops = 0;
        n_stall = 0;
        for (int k = 0; k < 20; k++) begin
            sq     = 1'($urandom_range(0, 1));
            rd     = 5'($urandom_range(0, 31));
            stalls = $urandom_range(0, 3);
            gap    = $urandom_range(0, 2);
            wbe    = wb_end(sq, stalls);
            wb0    = wbe - stalls;
            for (int t = 0; t <= wbe + gap; t++) begin
                if (t >= wb0 && t <= wbe) e3 = (t < wbe);
                else e3 = 1'($urandom_range(0, 1));
                step(t == 0, sq, rd, e3, 1'b0);
                e = model(t, sq, rd, stalls);
                checks++;
                if (obs() !== e) begin
                    errors++;
                    $display("FAIL rand op=%0d t=%0d got=%h exp=%h",
                             k, t, obs(), e);
                end
            end
            n_ops++;
            n_stall += wbe;
        end
`ifndef FP_DIVSQRT_PERF_EN
        n_ops = 0;
        n_stall = 0;
`endif
        checks++;
        if (bus.perf_ops !== 16'(n_ops) || bus.perf_stall !== 32'(n_stall)) begin
            errors++;
            $display("FAIL rand_perf got=%0d/%0d exp=%0d/%0d",
                     bus.perf_ops, bus.perf_stall, n_ops, n_stall);
        end
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL rand_err got=%b exp=0", bus.err);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.issue = 1'b0;
        bus.issue_sqrt = 1'b0;
        bus.issue_rd = 5'd0;
        bus.e3w = 1'b0;
        test_reset();
        test_fdiv();
        test_fsqrt();
        test_e3w_stall();
        test_issue_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
